// File: rtl/snitch_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter.
package snitch_rr_arbiter_pkg;

  // Output stage occupancy: EMPTY holds nothing, FULL holds one transfer.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rr_state_e;

endpackage

// File: rtl/onehot.sv
// One-hot detector: is_onehot_o is high when exactly one bit of d_i is set.
module onehot #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] d_i,
  output logic             is_onehot_o
);

  // Non-zero with no second set bit: clearing the lowest set bit leaves zero.
  always_comb begin
    is_onehot_o = (|d_i) && ((d_i & (d_i - Width'(1))) == '0);
  end

endmodule

// File: rtl/snitch_rr_arbiter.sv
// Round-robin arbiter with a one-entry registered output stage and a sticky
// one-hot grant self-check.
module snitch_rr_arbiter
  import snitch_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]                gnt_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DataWidth-1:0]             out_data_o,
  output logic [IdxWidth-1:0]              out_idx_o,
  output logic                             onehot_err_o
);

  rr_state_e               state_q, state_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic [IdxWidth-1:0]     idx_q, idx_d;
  logic [IdxWidth-1:0]     ptr_q, ptr_d;
  logic                    err_q, err_d;

  logic                    can_accept;
  logic                    found;
  logic                    grant;
  logic [IdxWidth-1:0]     win_idx;
  logic [IdxWidth-1:0]     ptr_next;
  logic [2*NumReq-1:0]     req_dbl;
  logic [NumReq-1:0]       req_rot;
  int                      offset;
  int                      win_int;

  // Separate net feeding the checker so the grant vector it sees is observable.
  logic [NumReq-1:0]       gnt_chk;
  logic                    gnt_is_onehot;

  assign out_valid_o  = (state_q == StFull);
  assign out_data_o   = data_q;
  assign out_idx_o    = idx_q;
  assign onehot_err_o = err_q;
  assign can_accept   = (state_q == StEmpty) || out_ready_i;

  // Rotate requests by ptr, find the lowest set bit, rotate the index back.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_q +: NumReq];
    found   = 1'b0;
    offset  = 0;
    for (int j = NumReq - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found  = 1'b1;
        offset = j;
      end
    end
    win_int = int'(ptr_q) + offset;
    if (win_int >= int'(NumReq)) begin
      win_int = win_int - int'(NumReq);
    end
    win_idx  = IdxWidth'(win_int);
    ptr_next = (win_int == int'(NumReq) - 1) ? '0 : IdxWidth'(win_int + 1);
  end

  // No grant while resetting or while the output stage is stalled.
  always_comb begin
    grant = found && can_accept && !rst_i;
    gnt_o = grant ? (NumReq'(1) << win_idx) : '0;
  end

  assign gnt_chk = gnt_o;

  onehot #(
    .Width(NumReq)
  ) i_gnt_onehot (
    .d_i        (gnt_chk),
    .is_onehot_o(gnt_is_onehot)
  );

  // Next-state: load on grant, drain on ready without grant, else hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    err_d   = err_q || ((|gnt_chk) && !gnt_is_onehot);
    if (grant) begin
      state_d = StFull;
      data_d  = req_data_i[win_idx];
      idx_d   = win_idx;
      ptr_d   = ptr_next;
    end else if ((state_q == StFull) && out_ready_i) begin
      state_d = StEmpty;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/snitch_rr_arbiter.md
# snitch_rr_arbiter

Round-robin arbiter that shares one downstream resource port among `NumReq` requesters with a valid/ready handshake and a one-entry registered output stage. Grants are self-checked for one-hotness by an instance of the existing `onehot` module, and any violation is latched in a sticky error flag. It sits in front of shared Snitch-side resources such as a shared functional unit or a TCDM port, between the requesting cores and the resource.

## Interface
- `NumReq`, default 4: number of requesters (≥1).
- `DataWidth`, default 32: payload width.
- `IdxWidth`, default `max(1, $clog2(NumReq))`: derived, not overridden.

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  NumReq  per-requester request.
- `req_data_i`  in  NumReq×DataWidth  per-requester payload.
- `gnt_o`  out  NumReq  per-requester grant; combinational, same cycle as accept.
- `out_valid_o`  out  1  output stage holds a transfer.
- `out_ready_i`  in  1  downstream accepts the transfer.
- `out_data_o`  out  DataWidth  registered payload of the winner.
- `out_idx_o`  out  IdxWidth  registered index of the winner.
- `onehot_err_o`  out  1  sticky: a grant vector was non-zero and not one-hot.

## Operation
- State: the output register (valid, data, idx), the priority pointer `ptr` (IdxWidth), and the sticky error bit.
- Two-state FSM on `out_valid_o`:
  - EMPTY (valid=0).
  - FULL (valid=1).
- `can_accept = !out_valid_o | out_ready_i`.
- Winner: the first index k with `req_i[k]`=1, scanning ptr, ptr+1, …, NumReq-1, 0, …, ptr-1.
- `gnt_o[k]` = 1 only when `can_accept` and k is the winner. All other grant bits are 0, and `gnt_o` = 0 if there is no request.
- On a grant:
  - next cycle: out_valid=1, out_data=req_data_i[k], out_idx=k;
  - ptr = k+1, wrapping to 0 when k = NumReq-1.
- FULL with `out_ready_i`=1 and no grant → EMPTY. FULL with `out_ready_i`=0 → hold all outputs stable and keep `gnt_o`=0.
- Back-to-back transfers: in FULL with `out_ready_i`=1 and a request present, grant and reload in the same cycle. Throughput is 1 transfer per cycle.
- `out_ready_i` while EMPTY is ignored.
- ptr changes only on a grant.
- Requesters hold `req_i` until granted. The arbiter tolerates a withdrawn request: that requester is simply not considered that cycle.
- One-hot check: `onehot` (Width=NumReq) is driven by `gnt_o`. If `|gnt_o & !is_onehot`, set `onehot_err_o` on the next edge. It is cleared only by reset.
- `NumReq`=1: ptr is constant 0 and `gnt_o[0] = req_i[0] & can_accept`.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_idx_o=0, ptr=0, onehot_err_o=0. `gnt_o`=0 during reset.
- Reset mid-transfer discards the held entry. No grant is issued in a reset cycle.
- Latency: grant at cycle t → out_valid_o at t+1.
- Combinational path from `req_i` and `out_ready_i` to `gnt_o` is allowed. No path from `out_ready_i` to `out_*` outputs.
- `onehot_err_o` asserts one cycle after the offending grant.
- Fairness: a continuously requesting requester is granted within NumReq grants.

## Structure
- No shared package is required. `IdxWidth` is a localparam.
- The priority pick is a rotate-by-ptr, leading-one detect, rotate-back function or generate loop.
- One sub-module instance only: `onehot` (`i_gnt_onehot`).
- Estimated size: 150–250 lines.

## Test plan
- Reset, then all `req_i`=0: `gnt_o`=0, out_valid_o=0, onehot_err_o=0, ptr=0.
- NumReq=4, `req_i`=4'b1111, `out_ready_i`=1 held:
  - grants 0,1,2,3,0,… one per cycle;
  - out_idx_o follows one cycle later;
  - out_data_o matches req_data_i[idx].
- `req_i`=4'b1010, ptr=0: grant 1, then 3, then 1. After granting 3, ptr wraps to 0.
- FULL with `out_ready_i`=0 for 5 cycles:
  - out_* stable and `gnt_o`=0 throughout;
  - raising `out_ready_i` grants the next requester in the same cycle.
- Reset asserted while FULL with a request pending: next cycle out_valid_o=0, ptr=0, no grant during reset.
- Force `gnt_o` to 4'b0110 (bench force on the checker input): onehot_err_o=1 next cycle, stays 1 until `rst_i`.
